// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter: round-robin sharing of one synchronous single-port RAM
// between the instruction-fetch port and the load/store port.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [3:0]        dm_wr_mask,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int   CNT_W  = 4;
  localparam logic WIN_IF = 1'b0;
  localparam logic WIN_DM = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t              state_q,     state_d;
  logic [CNT_W-1:0]    lat_cnt_q,   lat_cnt_d;
  logic                last_win_q,  last_win_d;
  logic                owner_q,     owner_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q,  dm_rdata_d;
  logic                win_dm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      lat_cnt_q   <= '0;
      last_win_q  <= WIN_IF;
      owner_q     <= WIN_IF;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      last_win_q  <= last_win_d;
      owner_q     <= owner_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    last_win_d  = last_win_q;
    owner_d     = owner_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    win_dm      = 1'b0;
    if_gnt      = 1'b0;
    dm_gnt      = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wmask   = '0;

    case (state_q)
      ST_IDLE: begin
        // Grants are suppressed while reset is asserted so outputs are quiet at once.
        if (rst && (if_req || dm_req)) begin
          win_dm     = dm_req && (!if_req || (last_win_q == WIN_IF));
          last_win_d = win_dm;
          mem_en     = 1'b1;
          if (win_dm) begin
            dm_gnt   = 1'b1;
            mem_addr = dm_addr;
            if (dm_we) begin
              mem_we    = 1'b1;
              mem_wdata = dm_wdata;
              mem_wmask = dm_wr_mask;
            end
          end else begin
            if_gnt   = 1'b1;
            mem_addr = if_addr;
          end
          if (!(win_dm && dm_we)) begin
            state_d   = ST_BUSY;
            lat_cnt_d = CNT_W'(RD_LAT);
            owner_d   = win_dm;
          end
        end
      end
      ST_BUSY: begin
        lat_cnt_d = lat_cnt_q - CNT_W'(1);
        if (lat_cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (owner_q == WIN_DM) begin
            dm_rdata_d  = mem_rdata;
            dm_rvalid_d = 1'b1;
          end else begin
            if_rdata_d  = mem_rdata;
            if_rvalid_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam logic [31:0] C_POISON = 32'hBAD0_0000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  // Instance A: RD_LAT=1
  logic        a_if_req, a_if_gnt, a_if_rvalid;
  logic [31:0] a_if_addr, a_if_rdata;
  logic        a_dm_req, a_dm_we, a_dm_gnt, a_dm_rvalid;
  logic [31:0] a_dm_addr, a_dm_wdata, a_dm_rdata;
  logic [3:0]  a_dm_wr_mask;
  logic        a_mem_en, a_mem_we;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_wmask;

  // Instance B: RD_LAT=3
  logic        b_if_req, b_if_gnt, b_if_rvalid;
  logic [31:0] b_if_addr, b_if_rdata;
  logic        b_dm_req, b_dm_we, b_dm_gnt, b_dm_rvalid;
  logic [31:0] b_dm_addr, b_dm_wdata, b_dm_rdata;
  logic [3:0]  b_dm_wr_mask;
  logic        b_mem_en, b_mem_we;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_wmask;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr),
    .dm_wdata(a_dm_wdata), .dm_wr_mask(a_dm_wr_mask), .dm_gnt(a_dm_gnt),
    .dm_rvalid(a_dm_rvalid), .dm_rdata(a_dm_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask), .mem_rdata(a_mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr),
    .dm_wdata(b_dm_wdata), .dm_wr_mask(b_dm_wr_mask), .dm_gnt(b_dm_gnt),
    .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask), .mem_rdata(b_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: non-read cycles return a poison word so mistimed capture shows up.
  logic [31:0] mem_a [64];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [3];

  function automatic logic [31:0] preset(input logic [31:0] addr);
    case (addr[7:2])
      6'd4:    preset = 32'h0025_8513;
      6'd16:   preset = 32'h1234_5678;
      default: preset = 32'h0000_0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= preset(32'(i * 4));
      pipe_a <= C_POISON;
    end else begin
      if (a_mem_en && a_mem_we)
        for (int i = 0; i < 4; i++)
          if (a_mem_wmask[i]) mem_a[a_mem_addr[7:2]][8*i +: 8] <= a_mem_wdata[8*i +: 8];
      pipe_a <= (a_mem_en && !a_mem_we) ? mem_a[a_mem_addr[7:2]] : C_POISON;
    end
  end
  assign a_mem_rdata = pipe_a;

  always @(posedge clk) begin
    pipe_b[0] <= (b_mem_en && !b_mem_we) ? preset(b_mem_addr) : C_POISON;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign b_mem_rdata = pipe_b[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_gnt [9];
  logic [1:0] exp_rv  [9];

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b0;
    a_if_req = 0; a_if_addr = 0; a_dm_req = 0; a_dm_we = 0;
    a_dm_addr = 0; a_dm_wdata = 0; a_dm_wr_mask = 0;
    b_if_req = 0; b_if_addr = 0; b_dm_req = 0; b_dm_we = 0;
    b_dm_addr = 0; b_dm_wdata = 0; b_dm_wr_mask = 0;

    // Reset state
    step(); step();
    check("rst_if_rvalid", a_if_rvalid, 0);
    check("rst_dm_rvalid", a_dm_rvalid, 0);
    check("rst_if_rdata",  a_if_rdata,  0);
    check("rst_dm_rdata",  a_dm_rdata,  0);
    check("rst_mem_en",    a_mem_en,    0);
    step(); rst = 1'b1; #2;
    check("idle_mem_en",   a_mem_en,   0);
    check("idle_mem_addr", a_mem_addr, 0);
    check("idle_gnts",     {a_if_gnt, a_dm_gnt}, 2'b00);

    // IF read, RD_LAT=1
    step(); a_if_req = 1; a_if_addr = 32'h10; #2;
    check("t2_if_gnt",    a_if_gnt,   1);
    check("t2_dm_gnt",    a_dm_gnt,   0);
    check("t2_mem_en",    a_mem_en,   1);
    check("t2_mem_we",    a_mem_we,   0);
    check("t2_mem_addr",  a_mem_addr, 32'h10);
    check("t2_mem_wmask", a_mem_wmask, 0);
    step(); a_if_req = 0; #2;
    check("t2_busy_gnt",  a_if_gnt,   0);
    check("t2_busy_en",   a_mem_en,   0);
    check("t2_early_rv",  a_if_rvalid, 0);
    step(); #2;
    check("t2_if_rvalid", a_if_rvalid, 1);
    check("t2_if_rdata",  a_if_rdata, 32'h0025_8513);

    // DM write with partial mask, then IF read back of the written word
    step();
    a_dm_req = 1; a_dm_we = 1; a_dm_addr = 32'h20;
    a_dm_wdata = 32'hDEAD_BEEF; a_dm_wr_mask = 4'b0011; #2;
    check("t3_dm_gnt",    a_dm_gnt,    1);
    check("t3_mem_we",    a_mem_we,    1);
    check("t3_mem_wmask", a_mem_wmask, 4'b0011);
    check("t3_mem_wdata", a_mem_wdata, 32'hDEAD_BEEF);
    check("t3_mem_addr",  a_mem_addr,  32'h20);
    check("t3_rv_1cyc",   a_if_rvalid, 0);
    step();
    a_dm_req = 0; a_dm_we = 0; a_dm_wdata = 0; a_dm_wr_mask = 0;
    a_if_req = 1; a_if_addr = 32'h20; #2;
    check("t3_if_gnt_t1", a_if_gnt,   1);
    check("t3_if_addr",   a_mem_addr, 32'h20);
    check("t3_no_dm_rv",  a_dm_rvalid, 0);
    step(); a_if_req = 0; #2;
    check("t3_no_dm_rv2", a_dm_rvalid, 0);
    step(); #2;
    check("t3_if_rvalid", a_if_rvalid, 1);
    check("t3_rdback",    a_if_rdata,  32'h0000_BEEF);

    // Both held: DM, IF, DM, IF, each two cycles apart
    exp_gnt = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
    exp_rv  = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    step();
    a_if_req = 1; a_if_addr = 32'h10; a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'h40;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) step();
      if (k == 8) begin a_if_req = 0; a_dm_req = 0; end
      #2;
      check($sformatf("t4_gnt_%0d", k), {a_if_gnt, a_dm_gnt}, exp_gnt[k]);
      check($sformatf("t4_rv_%0d", k), {a_if_rvalid, a_dm_rvalid}, exp_rv[k]);
      if (exp_rv[k][0]) check($sformatf("t4_dm_rdata_%0d", k), a_dm_rdata, 32'h1234_5678);
      if (exp_rv[k][1]) check($sformatf("t4_if_rdata_%0d", k), a_if_rdata, 32'h0025_8513);
    end

    // DM request raised during IF read
    step(); a_if_req = 1; a_if_addr = 32'h10; #2;
    check("t5_if_gnt", a_if_gnt, 1);
    step(); a_if_req = 0; a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'h40; #2;
    check("t5_dm_wait", a_dm_gnt, 0);
    check("t5_busy_en", a_mem_en, 0);
    step(); #2;
    check("t5_dm_gnt",    a_dm_gnt,    1);
    check("t5_if_rvalid", a_if_rvalid, 1);
    check("t5_mem_addr",  a_mem_addr,  32'h40);
    step(); a_dm_req = 0; #2;
    check("t5_dm_rv_early", a_dm_rvalid, 0);
    step(); #2;
    check("t5_dm_rvalid", a_dm_rvalid, 1);
    check("t5_dm_rdata",  a_dm_rdata,  32'h1234_5678);

    // Reset in the middle of a read
    step(); a_if_req = 1; a_if_addr = 32'h10; #2;
    check("t1_if_gnt", a_if_gnt, 1);
    step(); rst = 1'b0; a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'h40; #2;
    check("t1_gnts",     {a_if_gnt, a_dm_gnt}, 2'b00);
    check("t1_mem_en",   a_mem_en,    0);
    check("t1_mem_addr", a_mem_addr,  0);
    check("t1_if_rv",    a_if_rvalid, 0);
    check("t1_if_rdata", a_if_rdata,  0);
    check("t1_dm_rdata", a_dm_rdata,  0);
    step(); a_if_req = 0; a_dm_req = 0;
    step(); rst = 1'b1; #2;
    check("t1_no_rv_a", a_if_rvalid, 0);
    step(); #2;
    check("t1_no_rv_b", {a_if_rvalid, a_dm_rvalid}, 2'b00);
    step(); a_if_req = 1; a_dm_req = 1; #2;
    check("t1_conflict_dm", {a_if_gnt, a_dm_gnt}, 2'b01);
    step(); a_if_req = 0; a_dm_req = 0;
    step(); step();

    // RD_LAT=3 DM read on instance B
    step(); b_dm_req = 1; b_dm_we = 0; b_dm_addr = 32'h40; #2;
    check("t6_dm_gnt",   b_dm_gnt,   1);
    check("t6_mem_addr", b_mem_addr, 32'h40);
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) b_dm_req = 0;
      #2;
      check($sformatf("t6_rv_T%0d", k), b_dm_rvalid, (k == 4) ? 1 : 0);
      if (k == 4) check("t6_dm_rdata", b_dm_rdata, 32'h1234_5678);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
